// File: rtl/twiddle_axil_loader_if.sv
// AXI4-Lite bus bundle between the twiddle loader (master) and the
// correlator's coefficient port (slave).
interface twiddle_axil_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/twiddle_axil_loader.sv
// Streams complex twiddles into consecutive words of the correlator BRAM over
// AXI4-Lite, one serialized write (plus optional readback compare) per bin.
module twiddle_axil_loader #(
  parameter int DFT_LEN     = 128,
  parameter int TWIDD_WIDTH = 16,
  parameter int ADDR_WIDTH  = $clog2(DFT_LEN) + 3,
  parameter int VERIFY      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [31:0]                n_words,
  input  logic [TWIDD_WIDTH-1:0]     din_re,
  input  logic [TWIDD_WIDTH-1:0]     din_im,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err_resp,
  output logic                       mismatch,
  output logic [$clog2(DFT_LEN)-1:0] mismatch_idx,
  output logic [31:0]                words_done,
  twiddle_axil_loader_if.master      m_axil
);

  localparam int IDX_W  = $clog2(DFT_LEN);
  localparam int CNT_W  = IDX_W + 1;
  localparam int DATA_W = 2 * TWIDD_WIDTH;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_BRESP,
    S_RADDR,
    S_RDATA,
    S_NEXT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               err_q, err_d;
  logic               mm_q, mm_d;
  logic [IDX_W-1:0]   mm_idx_q, mm_idx_d;
  logic [31:0]        words_q, words_d;

  logic [CNT_W-1:0]   n_clamp;
  logic               awvalid;
  logic               wvalid;
  logic               bready;
  logic               arvalid;
  logic               rready;
  logic               aw_hs;
  logic               w_hs;

  // Requests beyond the table size load the whole table rather than wrap.
  always_comb begin
    n_clamp = n_words[CNT_W-1:0];
    if (n_words > 32'(DFT_LEN)) begin
      n_clamp = CNT_W'(DFT_LEN);
    end
  end

  assign aw_hs = awvalid && m_axil.awready;
  assign w_hs  = wvalid && m_axil.wready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    mm_d      = mm_q;
    mm_idx_d  = mm_idx_q;
    words_d   = words_q;
    din_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d    = 1'b0;
          mm_d     = 1'b0;
          mm_idx_d = '0;
          words_d  = '0;
          idx_d    = '0;
          last_d   = IDX_W'(n_clamp - CNT_W'(1));
          state_d  = (n_clamp == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        din_ready = 1'b1;
        if (din_valid) begin
          hold_d    = {din_im, din_re};
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WRITE;
        end
      end

      // Address and data channels complete independently, in either order.
      S_WRITE: begin
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = S_BRESP;
        end
      end

      S_BRESP: begin
        bready = 1'b1;
        if (m_axil.bvalid) begin
          if (m_axil.bresp != 2'b00) begin
            err_d = 1'b1;
          end
          state_d = (VERIFY != 0) ? S_RADDR : S_NEXT;
        end
      end

      S_RADDR: begin
        arvalid = 1'b1;
        if (m_axil.arready) begin
          state_d = S_RDATA;
        end
      end

      // A failed read carries no trustworthy data, so it never counts as a miscompare.
      S_RDATA: begin
        rready = 1'b1;
        if (m_axil.rvalid) begin
          if (m_axil.rresp != 2'b00) begin
            err_d = 1'b1;
          end else if ((m_axil.rdata != hold_q) && !mm_q) begin
            mm_d     = 1'b1;
            mm_idx_d = idx_q;
          end
          state_d = S_NEXT;
        end
      end

      S_NEXT: begin
        words_d = words_q + 32'd1;
        if (idx_q == last_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      hold_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      mm_q      <= 1'b0;
      mm_idx_q  <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      mm_q      <= mm_d;
      mm_idx_q  <= mm_idx_d;
      words_q   <= words_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err_resp     = err_q;
  assign mismatch     = mm_q;
  assign mismatch_idx = mm_idx_q;
  assign words_done   = words_q;

  assign m_axil.awaddr  = ADDR_WIDTH'({idx_q, 2'b00});
  assign m_axil.araddr  = ADDR_WIDTH'({idx_q, 2'b00});
  assign m_axil.awprot  = 3'b000;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.wdata   = hold_q;
  assign m_axil.awvalid = awvalid;
  assign m_axil.wvalid  = wvalid;
  assign m_axil.bready  = bready;
  assign m_axil.arvalid = arvalid;
  assign m_axil.rready  = rready;

  // Twiddle words are always written whole.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_wstrb
      assign m_axil.wstrb[gi] = 1'b1;
    end
  endgenerate

endmodule

// File: doc/twiddle_axil_loader.md
Name: twiddle_axil_loader

Overview:
- AXI4-Lite write initiator that fills the twiddle-factor BRAM of the single-bin DFT/correlator blocks.
- Takes a valid/ready stream of complex twiddles and issues one AXI-Lite write per bin to consecutive word addresses.
- Optionally reads each word back and compares it against what was written.
- Sits between a twiddle generator/host FIFO and the correlator's s_axil port. Lets the PL retune the DFT bin without the PS.

Parameters:
- DFT_LEN, 128: max number of bins; sets address range.
- TWIDD_WIDTH, 16: width of each of re/im; AXI data width is 2*TWIDD_WIDTH.
- ADDR_WIDTH, $clog2(DFT_LEN)+3: AXI byte-address width; matches the correlator's s_axil address port.
- VERIFY, 1: 1 = read back and compare each word after writing it; 0 = write only.

Ports:
- clk, input, 1: single clock for the stream and the AXI master.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a load; sampled only in IDLE.
- n_words, input, 32: number of bins to load; values above DFT_LEN are clamped to DFT_LEN.
- din_re, din_im, input, TWIDD_WIDTH each: twiddle word.
- din_valid, input, 1: stream valid.
- din_ready, output, 1: stream ready.
- busy, output, 1: high outside IDLE.
- done, output, 1: one-cycle pulse at the end of a load.
- err_resp, output, 1: sticky; set on any BRESP or RRESP != 0.
- mismatch, output, 1: sticky; set on a readback compare failure.
- mismatch_idx, output, $clog2(DFT_LEN): index of the first mismatch.
- words_done, output, 32: number of completed words.
- m_axil_awaddr, output, ADDR_WIDTH. m_axil_awprot, output, 3. m_axil_awvalid, output, 1. m_axil_awready, input, 1.
- m_axil_wdata, output, 2*TWIDD_WIDTH. m_axil_wstrb, output, 2*TWIDD_WIDTH/8. m_axil_wvalid, output, 1. m_axil_wready, input, 1.
- m_axil_bresp, input, 2. m_axil_bvalid, input, 1. m_axil_bready, output, 1.
- m_axil_araddr, output, ADDR_WIDTH. m_axil_arprot, output, 3. m_axil_arvalid, output, 1. m_axil_arready, input, 1.
- m_axil_rdata, input, 2*TWIDD_WIDTH. m_axil_rresp, input, 2. m_axil_rvalid, input, 1. m_axil_rready, output, 1.

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; idx=0.
  - All valid/ready/strobe-type outputs and done, busy, err_resp, mismatch are 0.
  - mismatch_idx=0, words_done=0.
  - Reset mid-transaction drops all valids immediately; the slave is reset by the same system reset.
- Constant outputs: awprot=arprot=3'b000; wstrb all ones.
- Address and data:
  - awaddr = araddr = idx<<2.
  - wdata = {din_im, din_re}, real part in the lower TWIDD_WIDTH bits.
- FSM states: IDLE, FETCH, WRITE, BRESP, RADDR, RDATA, NEXT, DONE.
- IDLE:
  - On start: clear err_resp, mismatch, mismatch_idx, words_done and idx.
  - Go to DONE if clamped n_words==0, else FETCH.
  - start while busy is ignored.
- FETCH:
  - din_ready=1.
  - On din_valid, latch the word into a hold register and go to WRITE. awvalid and wvalid are both asserted the next cycle.
- WRITE:
  - awvalid and wvalid are independent; each deasserts the cycle after its own handshake.
  - Either channel may complete first, or both in the same cycle.
  - Leave for BRESP once both have completed.
  - awaddr and wdata are stable while their valid is high.
- BRESP:
  - bready=1.
  - On bvalid: if bresp!=0, set err_resp.
  - Next state is RADDR if VERIFY, else NEXT.
- RADDR: arvalid=1 until arready, then RDATA.
- RDATA:
  - rready=1.
  - On rvalid: if rresp!=0, set err_resp.
  - Else, if rdata != hold and mismatch==0: set mismatch and set mismatch_idx=idx.
  - Go to NEXT.
- NEXT:
  - words_done++.
  - If idx==clamped n_words-1, go to DONE; else idx++ and go to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- No outstanding-transaction overlap: at most one write and one read in flight, strictly serialized.
- Minimum per-word latency with an always-ready slave: VERIFY=0 takes 4 cycles (FETCH, WRITE, BRESP, NEXT); VERIFY=1 takes 6 cycles.
- An error does not abort the load; all words are still written.

Test Plan:
- Always-ready slave model, VERIFY=1, n_words=4, words (re,im)=(0x4000,0x0000),(0x2D41,0xD2BF),... -> awaddr 0x0,0x4,0x8,0xC; wdata {im,re}; done after 24 cycles; err_resp=0, mismatch=0, words_done=4.
- Slave gives awready 3 cycles before wready, then the reverse, then both in the same cycle -> each valid drops right after its own handshake; exactly one write per word; bready only after both channels complete.
- Slave returns BRESP=2'b10 on word 1 of 3 -> err_resp=1 sticky through done; all 3 words still written; a new start clears err_resp.
- Slave corrupts readback of word 2 and word 5, n_words=8 -> mismatch=1, mismatch_idx=2 (first mismatch only).
- n_words=0 -> done one cycle after start, no AXI valids. n_words=1000 with DFT_LEN=128 -> 128 writes, last awaddr 0x1FC.
- Assert rst during WRITE with awvalid high -> all valids 0 in the same cycle; then start works normally. din_valid gaps of 5 cycles -> FETCH waits, no AXI activity.
